// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed when the operation starts and committed to HI/LO once the busy window ends.
//
// state  | meaning
// S_IDLE | accepts mult/div/mthi/mtlo; busy=0
// S_RUN  | counting down; result staged in r_hi_s/r_lo_s; busy=1
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CN_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW     = $clog2(CN_MAX + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic [31:0]      r_hi,    w_hi_nxt;
  logic [31:0]      r_lo,    w_lo_nxt;
  logic [31:0]      r_hi_s,  w_hi_s_nxt;
  logic [31:0]      r_lo_s,  w_lo_s_nxt;
  logic             r_dz,    w_dz_nxt;

  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_a_mag, w_b_mag, w_bm_safe, w_bu_safe;
  logic [31:0]        w_mq, w_mr, w_sq, w_sr, w_uq, w_ur;

  assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
  assign w_a_mag   = a[31] ? -a : a;
  assign w_b_mag   = b[31] ? -b : b;
  assign w_bm_safe = (b == 32'd0) ? 32'd1 : w_b_mag;
  assign w_bu_safe = (b == 32'd0) ? 32'd1 : b;
  assign w_mq      = w_a_mag / w_bm_safe;
  assign w_mr      = w_a_mag % w_bm_safe;
  assign w_sq      = (a[31] ^ b[31]) ? -w_mq : w_mq;
  assign w_sr      = a[31] ? -w_mr : w_mr;
  assign w_uq      = a / w_bu_safe;
  assign w_ur      = a % w_bu_safe;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_hi_s_nxt  = r_hi_s;
    w_lo_s_nxt  = r_lo_s;
    w_dz_nxt    = r_dz;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'd0: begin
              {w_hi_s_nxt, w_lo_s_nxt} = w_prod_s;
              w_cnt_nxt   = MULT_N;
              w_dz_nxt    = 1'b0;
              w_state_nxt = S_RUN;
            end
            3'd1: begin
              {w_hi_s_nxt, w_lo_s_nxt} = w_prod_u;
              w_cnt_nxt   = MULT_N;
              w_dz_nxt    = 1'b0;
              w_state_nxt = S_RUN;
            end
            3'd2: begin
              w_hi_s_nxt  = w_sr;
              w_lo_s_nxt  = w_sq;
              w_cnt_nxt   = DIV_N;
              w_dz_nxt    = (b == 32'd0);
              w_state_nxt = S_RUN;
            end
            3'd3: begin
              w_hi_s_nxt  = w_ur;
              w_lo_s_nxt  = w_uq;
              w_cnt_nxt   = DIV_N;
              w_dz_nxt    = (b == 32'd0);
              w_state_nxt = S_RUN;
            end
            3'd4:    w_hi_nxt = a;
            3'd5:    w_lo_nxt = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - 1'b1;
        // <=1 rather than ==1 so a corrupted zero count cannot wedge the unit busy.
        if (r_cnt <= 1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          if (!r_dz) begin
            w_hi_nxt = r_hi_s;
            w_lo_nxt = r_lo_s;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_hi_s  <= '0;
      r_lo_s  <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_hi_s  <= w_hi_s_nxt;
      r_lo_s  <= w_lo_s_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: expected HI/LO and busy length are queued at issue and checked at commit.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [31:0] eh;
    logic [31:0] el;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] m_hi, m_lo;

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integers; divide by zero leaves HI/LO untouched.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: return 64'(sx * sy);
      3'd1: return ux * uy;
      3'd2: begin
        if (y == 32'd0) return {m_hi, m_lo};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {m_hi, m_lo};
        return {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting clock edge.
  task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    if (o < 3'd4) begin
      e.tag = tag; e.eh = eh; e.el = el;
      e.cyc = (o < 3'd2) ? 5 : 10;
      sb_q.push_back(e);
    end
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'd6;
    if (o < 3'd4) begin
      check({tag, " busy_rise"}, 32'(busy), 32'd1);
    end else begin
      if (o == 3'd4) m_hi = x;
      if (o == 3'd5) m_lo = x;
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " hi"}, hi, m_hi);
      check({tag, " lo"}, lo, m_lo);
    end
  endtask

  task automatic wait_done(input bit inject);
    exp_t e;
    int   cyc = 0;
    while (busy === 1'b1 && cyc < 64) begin
      cyc++;
      check("hold hi", hi, m_hi);
      check("hold lo", lo, m_lo);
      a = $urandom; b = $urandom;
      start = inject && (cyc == 2);
      op = start ? 3'd4 : 3'd6;
      if (start) a = 32'hDEADBEEF;
      @(negedge clk);
    end
    start = 1'b0; op = 3'd6;
    if (sb_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard: got empty queue required pending entry");
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, " busy_cycles"}, 32'(cyc), 32'(e.cyc));
    check({e.tag, " hi"}, hi, e.eh);
    check({e.tag, " lo"}, lo, e.el);
    m_hi = e.eh;
    m_lo = e.el;
  endtask

  initial begin
    logic [63:0] r;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    bit          saw_busy;
    exp_t        dropped;

    reset = 1'b0; start = 1'b0; op = 3'd6; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", 32'(busy), 32'd0);

    // back-to-back mthi / mtlo
    start = 1'b1; op = 3'd4; a = 32'h12345678;
    @(negedge clk);
    check("mthi hi", hi, 32'h12345678);
    check("mthi busy", 32'(busy), 32'd0);
    op = 3'd5; a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0; op = 3'd6;
    check("mtlo lo", lo, 32'h9ABCDEF0);
    check("mtlo hi", hi, 32'h12345678);
    check("mtlo busy", 32'(busy), 32'd0);
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

    issue("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    wait_done(1'b0);
    issue("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
    wait_done(1'b0);

    issue("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_done(1'b0);
    issue("divu", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3);
    wait_done(1'b0);
    issue("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    wait_done(1'b0);

    issue("pre_mthi", 3'd4, 32'hAAAAAAAA, 32'd0, 32'd0, 32'd0);
    issue("pre_mtlo", 3'd5, 32'h55555555, 32'd0, 32'd0, 32'd0);
    issue("div_zero", 3'd2, 32'd5, 32'd0, 32'hAAAAAAAA, 32'h55555555);
    wait_done(1'b0);

    // mult with mthi injected and operands churned during RUN, then divu on the first idle cycle
    r = model(3'd0, 32'h00001234, 32'hFFFFFF00);
    issue("mult_inj", 3'd0, 32'h00001234, 32'hFFFFFF00, r[63:32], r[31:0]);
    wait_done(1'b1);
    issue("divu_b2b", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_done(1'b0);

    for (int k = 0; k < 6; k++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (k == 3) ? 32'd0 : $urandom;
      if (k == 4) rb = 32'(ra[3:0]) + 32'd1;
      r = model(ro, ra, rb);
      issue($sformatf("rand%0d_op%0d", k, ro), ro, ra, rb, r[63:32], r[31:0]);
      wait_done(1'b0);
    end

    // reset in cycle 4 of a div discards it
    issue("div_rst", 3'd2, 32'd1000, 32'd7, 32'd6, 32'd142);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    dropped = sb_q.pop_front();
    m_hi = '0; m_lo = '0;
    saw_busy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0) saw_busy = 1'b1;
    end
    check("postrst no_busy", 32'(saw_busy), 32'd0);
    check("postrst hi", hi, 32'd0);
    check("postrst lo", lo, 32'd0);
    r = model(3'd0, 32'hFFFFFFF9, 32'd3);
    issue("mult_after_rst", 3'd0, 32'hFFFFFFF9, 32'd3, r[63:32], r[31:0]);
    wait_done(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the P6 pipelined MIPS core.
- Sits in the EX stage. It consumes the forwarded rs/rt operand values.
- It exposes busy to the hazard unit so that later MDU instructions stall.
- It exposes HI/LO to the EX-stage result path for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal range >=1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (legal range >=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets).
- start  input  1  one-cycle request; qualified by op.
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7=no-op.
- a  input  32  operand rs (dividend / multiplicand / mthi-mtlo source).
- b  input  32  operand rt (divisor / multiplier).
- busy  output  1  operation in progress.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset==0 at an edge): hi=0, lo=0, busy=0, counter=0, staging cleared. Reset has priority over everything, including an operation in flight, which is discarded.
- States: IDLE (busy=0), RUN (busy=1). Outputs are registered only; nothing is combinational from inputs.
- IDLE, start=1, op in {0..3}, at edge E0:
  - Compute the 64-bit result into staging registers hi_s/lo_s.
  - Load counter = MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3).
  - Go to RUN with busy=1.
- RUN: each edge decrements counter. At the edge where counter==1:
  - hi<=hi_s and lo<=lo_s.
  - busy<=0; return to IDLE.
  - busy is therefore high for exactly N cycles after E0, and new hi/lo are visible from edge E0+N.
- Arithmetic:
  - mult: {hi,lo} = signed(a)*signed(b), full 64 bits.
  - multu: the same, unsigned.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Corner cases:
  - div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero (b==0, op 2/3): the busy sequence runs normally but hi/lo are left unchanged at commit.
- mthi/mtlo (op 4/5) with start=1 in IDLE: hi<=a (or lo<=a) at the next edge. busy stays 0 and no RUN is entered.
- start while busy=1: ignored entirely, for any op. The hazard unit guarantees this does not happen; the block must still be robust.
- start in the same cycle that busy falls: this is the cycle after commit, in IDLE, so it is accepted normally.
- op 6/7 with start=1: no state change.
- Operands are sampled only at E0. Changes to a/b during RUN have no effect.
- hi/lo hold their old values throughout RUN until commit.

Test Plan:
1. Reset low for 2 edges, then high. Required: hi=0, lo=0, busy=0.
   Then mthi a=0x12345678 and mtlo a=0x9ABCDEF0 on consecutive cycles. Required: hi/lo equal these values one edge later; busy never rises.
2. mult a=0xFFFFFFFE (-2), b=0x00000003.
   Required: busy high exactly 5 cycles; old hi/lo held during RUN; after edge E0+5, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
   Then multu with the same operands. Required: hi=0x00000002, lo=0xFFFFFFFA.
3. div a=0xFFFFFFF9 (-7), b=0x00000002.
   Required: busy high for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   Then divu a=7, b=2. Required: lo=3, hi=1.
   Then div a=0x80000000, b=0xFFFFFFFF. Required: lo=0x80000000, hi=0.
4. Divide by zero: preload hi=0xAAAAAAAA and lo=0x55555555, then div a=5, b=0.
   Required: busy high for 10 cycles; hi/lo unchanged afterwards.
5. During a mult RUN, pulse start with mthi a=0xDEADBEEF, and change a/b every cycle.
   Required: the mthi is ignored; the result matches the operands sampled at E0.
   Then start divu on the first cycle busy==0. Required: it is accepted and busy rises at the next edge.
6. Start div, then drive reset low in cycle 4 of RUN.
   Required: at that edge busy=0, hi=0, lo=0, and no later commit occurs.
   After reset is released, a new mult completes correctly.
